// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame receiver.
// Contents:
//   rx_state_t  - receiver FSM states
//   LINE_IDLE   - idle / stop level of the serial line
package serial_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Bundle of the serial line input and the received-word output slot.
// Ports (master = receiver side):
//   bit_valid, serial_in  line bit and its qualifier (into the receiver)
//   data_out, data_valid  received word and slot-full flag (out of the receiver)
//   data_ready            consumer accept (into the receiver)
//   parity_error          parity status of the word in the slot
//   frame_error, overrun  one-cycle status pulses
//   busy                  receiver is inside a frame
interface serial_frame_receiver_if #(
    parameter int N = 4
);
    logic         bit_valid;
    logic         serial_in;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         parity_error;
    logic         frame_error;
    logic         overrun;
    logic         busy;

    modport master (
        input  bit_valid,
        input  serial_in,
        input  data_ready,
        output data_out,
        output data_valid,
        output parity_error,
        output frame_error,
        output overrun,
        output busy
    );

    modport slave (
        output bit_valid,
        output serial_in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  frame_error,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/rx_out_slot.sv
// One-entry valid/ready output register for received words.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        a word completed this cycle
//   load_data   completed word
//   load_perr   parity status of the completed word
//   ready       consumer accept
//   data, perr  registered word and its parity status
//   valid       slot full
//   overrun     one-cycle pulse when a completed word was dropped
module rx_out_slot #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         load_perr,
    input  logic         ready,
    output logic [N-1:0] data,
    output logic         valid,
    output logic         perr,
    output logic         overrun
);

    logic xfer;

    assign xfer = valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            perr    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                // A transfer in the same cycle frees the slot for the new word.
                if (!valid || xfer) begin
                    data  <= load_data;
                    perr  <= load_perr;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Recovers LSB-first framed words from a qualified serial bit stream.
// Frame: start (0), N data bits LSB first, optional parity bit, stop (1).
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       serial_frame_receiver_if.master: line input, output slot
//             (data_out/data_valid/data_ready/parity_error) and status
//             (frame_error, overrun, busy)
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int N          = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic rst,
    serial_frame_receiver_if.master bus
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    rx_state_t    state;
    rx_state_t    state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0] sreg;
    logic         perr;
    logic         last_bit;
    logic         complete;
    logic         ferr_set;
    logic         frame_error_r;
    logic         busy;

    assign last_bit = (cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; only qualified bits advance the FSM
    always_comb begin
        state_nx = state;
        if (bus.bit_valid) begin
            case (state)
                RX_IDLE:   if (bus.serial_in != LINE_IDLE) state_nx = RX_DATA;
                RX_DATA:   if (last_bit) state_nx = PARITY_EN ? RX_PARITY : RX_STOP;
                RX_PARITY: state_nx = RX_STOP;
                // A 0 stop bit returns to IDLE without being taken as a new start.
                RX_STOP:   state_nx = RX_IDLE;
                default:   state_nx = RX_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy     = (state != RX_IDLE);
        complete = (state == RX_STOP) && bus.bit_valid && (bus.serial_in == LINE_IDLE);
        ferr_set = (state == RX_STOP) && bus.bit_valid && (bus.serial_in != LINE_IDLE);
    end

    // Counter, shift register, parity capture and frame-error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            sreg          <= '0;
            perr          <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            frame_error_r <= ferr_set;
            if (bus.bit_valid) begin
                case (state)
                    RX_IDLE: begin
                        if (bus.serial_in != LINE_IDLE) begin
                            cnt  <= '0;
                            perr <= 1'b0;
                        end
                    end
                    RX_DATA: begin
                        sreg <= {bus.serial_in, sreg[N-1:1]};
                        // Park at 0 after the last bit instead of wrapping.
                        cnt  <= last_bit ? '0 : cnt + 1'b1;
                    end
                    RX_PARITY: begin
                        perr <= ((^sreg) ^ bus.serial_in) != PARITY_ODD;
                    end
                    default: ;
                endcase
            end
        end
    end

    rx_out_slot #(.N(N)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data (sreg),
        .load_perr (perr),
        .ready     (bus.data_ready),
        .data      (bus.data_out),
        .valid     (bus.data_valid),
        .perr      (bus.parity_error),
        .overrun   (bus.overrun)
    );

    assign bus.frame_error = frame_error_r;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver (N=4, even parity enabled).
module tb_serial_frame_receiver;

    localparam int N          = 4;
    localparam bit PARITY_EN  = 1'b1;
    localparam bit PARITY_ODD = 1'b0;

    logic clk = 1'b0;
    logic rst;

    serial_frame_receiver_if #(.N(N)) bus ();

    serial_frame_receiver #(
        .N          (N),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] data;
        logic         perr;
    } word_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_overrun = 0, obs_overrun = 0;
    int    exp_ferr = 0,    obs_ferr = 0;

    // Model of the output slot, updated once per clock edge by the driver.
    bit    m_full = 1'b0;
    bit    m_stop_good = 1'b0;
    word_t m_word;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_edge();
        bit xfer;
        if (rst) begin
            m_full = 1'b0;
            exp_q.delete();
            return;
        end
        xfer = m_full && bus.data_ready;
        if (m_stop_good) begin
            if (!m_full || xfer) begin
                exp_q.push_back(m_word);
                m_full = 1'b1;
            end else begin
                exp_overrun++;
            end
        end else if (xfer) begin
            m_full = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(int n);
        bus.bit_valid = 1'b0;
        bus.serial_in = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // Sends one frame. gap = idle (bit_valid=0) cycles before each bit;
    // rdy_rand randomizes data_ready per cycle; rdy_stop >= 0 forces data_ready
    // for the stop-bit cycle. Returns 1 time unit after the stop-bit edge.
    task automatic send_frame(logic [N-1:0] w, bit bad_par, bit bad_stop,
                              int gap, bit rdy_rand, int rdy_stop);
        logic bits[$];
        int   ones;
        logic pbit;
        ones = $countones(w);
        pbit = logic'(ones % 2) ^ PARITY_ODD ^ bad_par;
        bits.push_back(1'b0);
        for (int i = 0; i < N; i++) bits.push_back(w[i]);
        if (PARITY_EN) bits.push_back(pbit);
        bits.push_back(bad_stop ? 1'b0 : 1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int g = 0; g < gap; g++) begin
                bus.bit_valid = 1'b0;
                bus.serial_in = 1'($urandom_range(0, 1));
                if (rdy_rand) bus.data_ready = 1'($urandom_range(0, 1));
                step();
            end
            bus.bit_valid = 1'b1;
            bus.serial_in = bits[b];
            if (rdy_rand) bus.data_ready = 1'($urandom_range(0, 1));
            if (b == bits.size() - 1) begin
                if (rdy_stop >= 0) bus.data_ready = 1'(rdy_stop);
                if (!bad_stop) begin
                    m_word.data = w;
                    m_word.perr = PARITY_EN ? (((ones + int'(pbit)) % 2) != int'(PARITY_ODD)) : 1'b0;
                    m_stop_good = 1'b1;
                end else begin
                    exp_ferr++;
                end
            end
            step();
            m_stop_good = 1'b0;
        end
        bus.bit_valid = 1'b0;
        bus.serial_in = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks pulses/holding.
    bit           hold_pend = 1'b0;
    logic [N-1:0] hold_data;
    logic         hold_perr;
    bit           prev_ovr = 1'b0, prev_ferr = 1'b0;

    always @(negedge clk) begin
        word_t e;
        if (rst) begin
            hold_pend = 1'b0;
            prev_ovr  = 1'b0;
            prev_ferr = 1'b0;
        end else begin
            if (bus.overrun) begin
                obs_overrun++;
                if (prev_ovr) chk("overrun_pulse_width", 32'(bus.overrun), 32'd0);
            end
            if (bus.frame_error) begin
                obs_ferr++;
                if (prev_ferr) chk("frame_error_pulse_width", 32'(bus.frame_error), 32'd0);
            end
            prev_ovr  = bus.overrun;
            prev_ferr = bus.frame_error;
            if (hold_pend) begin
                chk("hold_valid", 32'(bus.data_valid), 32'd1);
                chk("hold_data", 32'(bus.data_out), 32'(hold_data));
                chk("hold_perr", 32'(bus.parity_error), 32'(hold_perr));
            end
            if (bus.data_valid && bus.data_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(bus.data_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(bus.data_out), 32'(e.data));
                    chk("parity_error", 32'(bus.parity_error), 32'(e.perr));
                end
            end
            hold_pend = bus.data_valid && !bus.data_ready;
            hold_data = bus.data_out;
            hold_perr = bus.parity_error;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1);
    end

    task automatic check_all_zero(string tag);
        chk({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
        chk({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
        chk({tag, "_parity_error"}, 32'(bus.parity_error), 32'd0);
        chk({tag, "_frame_error"}, 32'(bus.frame_error), 32'd0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.bit_valid  = 1'b0;
        bus.serial_in  = 1'b1;
        bus.data_ready = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Good frame 0xD, then bad parity on the same word
        bus.data_ready = 1'b1;
        send_frame(4'hD, 1'b0, 1'b0, 0, 1'b0, -1);
        chk("good_valid_next", 32'(bus.data_valid), 32'd1);
        idle(1);
        chk("good_valid_one_cycle", 32'(bus.data_valid), 32'd0);
        send_frame(4'hD, 1'b1, 1'b0, 0, 1'b0, -1);
        chk("badpar_valid", 32'(bus.data_valid), 32'd1);
        chk("badpar_perr", 32'(bus.parity_error), 32'd1);
        idle(2);

        // Bad stop bit, then an extra 1 must leave the receiver idle
        send_frame(4'h8, 1'b0, 1'b1, 0, 1'b0, -1);
        chk("badstop_ferr", 32'(bus.frame_error), 32'd1);
        chk("badstop_no_valid", 32'(bus.data_valid), 32'd0);
        chk("badstop_idle", 32'(bus.busy), 32'd0);
        bus.bit_valid = 1'b1;
        bus.serial_in = 1'b1;
        step();
        bus.bit_valid = 1'b0;
        chk("badstop_ferr_drop", 32'(bus.frame_error), 32'd0);
        chk("after_one_idle", 32'(bus.busy), 32'd0);
        idle(1);

        // Reset mid-frame, then a clean frame
        bus.bit_valid = 1'b1;
        bus.serial_in = 1'b0; step();
        bus.serial_in = 1'b1; step();
        bus.serial_in = 1'b0; step();
        chk("midframe_busy", 32'(bus.busy), 32'd1);
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        check_all_zero("midreset");
        rst = 1'b0;
        step();
        send_frame(4'hA, 1'b0, 1'b0, 0, 1'b0, -1);
        idle(2);

        // Backpressure: second word dropped with one overrun pulse
        bus.data_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b0, 0, 1'b0, -1);
        send_frame(4'h5, 1'b0, 1'b0, 0, 1'b0, -1);
        idle(1);
        chk("bp_data_held", 32'(bus.data_out), 32'h3);
        chk("bp_valid_held", 32'(bus.data_valid), 32'd1);
        chk("bp_overrun_count", 32'(obs_overrun), 32'd1);
        idle(2);
        bus.data_ready = 1'b1;
        idle(2);
        chk("bp_drained", 32'(bus.data_valid), 32'd0);

        // Gapped bits with a completion in the same cycle as a transfer
        bus.data_ready = 1'b0;
        send_frame(4'h6, 1'b0, 1'b0, 2, 1'b0, -1);
        send_frame(4'h9, 1'b0, 1'b0, 2, 1'b0, 1);
        chk("same_cycle_valid", 32'(bus.data_valid), 32'd1);
        chk("same_cycle_data", 32'(bus.data_out), 32'h9);
        chk("same_cycle_no_overrun", 32'(bus.overrun), 32'd0);
        idle(2);

        // Randomized traffic
        for (int f = 0; f < 60; f++) begin
            send_frame(N'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) == 0), $urandom_range(0, 2), 1'b1, -1);
            bus.data_ready = 1'($urandom_range(0, 1));
            idle($urandom_range(0, 2));
        end

        bus.data_ready = 1'b1;
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("overrun_total", 32'(obs_overrun), 32'(exp_overrun));
        chk("frame_error_total", 32'(obs_ferr), 32'(exp_ferr));
        chk("final_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
